// File: rtl/glyph_row_reader.sv
// Reads the 8 row bytes of one glyph from the falling-edge bitmap ROM and
// serializes each row MSB-first as single pixels over a valid/ready stream.
module glyph_row_reader #(
    parameter int GLYPH_W = 7,
    parameter int ROW_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [GLYPH_W-1:0]   glyph,
    output logic                 busy,
    output logic                 done,
    output logic                 rom_enable,
    output logic [GLYPH_W+2:0]   rom_address,
    input  logic [ROW_W-1:0]     rom_data,
    output logic                 pixel_valid,
    input  logic                 pixel_ready,
    output logic                 pixel,
    output logic [2:0]           pixel_x,
    output logic [2:0]           pixel_y
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        SHIFT   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [2:0] LAST_COL = 3'(ROW_W - 1);
    localparam logic [2:0] LAST_ROW = 3'd7;

    state_t               state;
    state_t               state_next;
    logic [GLYPH_W-1:0]   glyph_q;
    logic [2:0]           row;
    logic [2:0]           col;
    logic [ROW_W-1:0]     shreg;
    logic                 handshake;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output and next-state value gets a default before the case,
    // so no path through the block can leave a signal unassigned (no latches).
    always_comb begin
        state_next  = state;
        busy        = (state != IDLE);
        done        = 1'b0;
        rom_enable  = 1'b0;
        pixel_valid = 1'b0;
        unique case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH: begin
                rom_enable = 1'b1;
                state_next = CAPTURE;
            end
            CAPTURE: state_next = SHIFT;
            SHIFT: begin
                pixel_valid = 1'b1;
                if (pixel_ready && col == LAST_COL) begin
                    state_next = (row == LAST_ROW) ? DONE : FETCH;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign handshake   = (state == SHIFT) && pixel_ready;
    assign rom_address = {glyph_q, row};
    assign pixel       = shreg[ROW_W-1];
    assign pixel_x     = col;
    assign pixel_y     = row;

    // NOTE: all datapath registers are reset so an abandoned glyph leaves every
    // output at zero on the next cycle; there is no memory array here to exempt.
    always_ff @(posedge clock) begin
        if (reset) begin
            glyph_q <= '0;
            row     <= '0;
            col     <= '0;
            shreg   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        glyph_q <= glyph;
                        row     <= '0;
                    end
                end
                CAPTURE: begin
                    shreg <= rom_data;
                    col   <= '0;
                end
                SHIFT: begin
                    if (handshake) begin
                        shreg <= {shreg[ROW_W-2:0], 1'b0};
                        col   <= col + 3'd1;
                        // The last column of row 7 wraps the row counter back to 0.
                        if (col == LAST_COL) row <= row + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_row_reader.sv
// Self-checking bench for glyph_row_reader: a falling-edge ROM model plus an
// expected pixel/address stream derived directly from the ROM contents.
module tb_glyph_row_reader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [6:0]  glyph;
    logic        busy;
    logic        done;
    logic        rom_enable;
    logic [9:0]  rom_address;
    logic [7:0]  rom_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        pixel;
    logic [2:0]  pixel_x;
    logic [2:0]  pixel_y;

    logic [7:0]  rom_mem [0:1023];
    logic [20:0] all_outs;

    int checks = 0;
    int errors = 0;

    glyph_row_reader #(.GLYPH_W(7), .ROW_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .glyph       (glyph),
        .busy        (busy),
        .done        (done),
        .rom_enable  (rom_enable),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel       (pixel),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bitmap ROM: output registered on the falling edge while enabled.
    initial rom_data = 8'h00;
    always @(negedge clock) begin
        if (rom_enable) rom_data <= rom_mem[rom_address];
    end

    assign all_outs = {busy, done, rom_enable, rom_address, pixel_valid, pixel, pixel_x, pixel_y};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // mode 0: always ready, 1: toggles every cycle, 2: random.
    function automatic logic pick_ready(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Runs one glyph from an idle negedge (cycle 0) through the first idle cycle after done.
    task automatic run_glyph(input logic [6:0] g, input int mode, input bit inject, input bit hold);
        logic [6:0] exp_px[$];
        logic [9:0] exp_addr[$];
        logic [6:0] held;
        logic [7:0] row_bits;
        int cyc, stalls, fetches, first_valid;
        bit stalled, injected, got_done;
        for (int r = 0; r < 8; r++) begin
            row_bits = rom_mem[{g, 3'(r)}];
            exp_addr.push_back({g, 3'(r)});
            for (int x = 0; x < 8; x++) exp_px.push_back({row_bits[7 - x], 3'(x), 3'(r)});
        end
        check("idle_before_start", busy, 0);
        glyph = g;
        start = 1'b1;
        pixel_ready = 1'b1;
        cyc = 0; stalls = 0; fetches = 0; first_valid = -1;
        stalled = 0; injected = 0; got_done = 0; held = '0;
        while (!got_done && cyc < 600) begin
            @(negedge clock);
            cyc++;
            start = hold;
            if (cyc == 1) check("fetch_at_cycle1", rom_enable, 1);
            check("busy_while_active", busy, 1);
            if (rom_enable) begin
                fetches++;
                if (exp_addr.size() == 0) check("extra_fetch", fetches, 8);
                else check("rom_address", rom_address, exp_addr.pop_front());
            end
            if (stalled) check("stall_hold", {pixel_valid, pixel, pixel_x, pixel_y}, {1'b1, held});
            if (pixel_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    check("first_valid_cycle", cyc, 3);
                end
                pixel_ready = pick_ready(mode, cyc);
                if (pixel_ready) begin
                    stalled = 0;
                    if (exp_px.size() == 0) check("extra_pixel", exp_px.size(), 1);
                    else check("pixel_xy", {pixel, pixel_x, pixel_y}, exp_px.pop_front());
                end else begin
                    stalls++;
                    stalled = 1;
                    held = {pixel, pixel_x, pixel_y};
                end
            end else begin
                stalled = 0;
                pixel_ready = pick_ready(mode, cyc);
            end
            if (inject && !injected && pixel_valid && pixel_y == 3'd3) begin
                start = 1'b1;
                glyph = 7'h7F;
                injected = 1;
            end
            if (done) begin
                got_done = 1;
                // 81 cycles unstalled, plus one per low-ready cycle in SHIFT.
                check("done_cycle", cyc, 81 + stalls);
                check("no_pixel_with_done", pixel_valid, 0);
                check("pixels_left", exp_px.size(), 0);
                check("fetch_count", fetches, 8);
            end
        end
        check("done_seen", got_done, 1);
        @(negedge clock);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        int fetches;
        bit any_done;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 8'($urandom);
        for (int n = 0; n < 8; n++) rom_mem[{7'h05, 3'(n)}] = 8'hA0 + 8'(n);

        reset = 1'b1; start = 1'b0; glyph = '0; pixel_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_state", all_outs, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_after_reset", all_outs, 0);

        // Basic glyph, no backpressure.
        run_glyph(7'h05, 0, 0, 0);
        // Backpressure: ready toggling every cycle.
        run_glyph(7'h05, 1, 0, 0);
        // Ignored start during row 3, then stay idle.
        run_glyph(7'h05, 0, 1, 0);
        repeat (3) begin
            @(negedge clock);
            check("ignored_start_idle", {busy, rom_enable}, 0);
        end
        // Address boundary.
        run_glyph(7'h7F, 0, 0, 0);
        check("row_wrapped", pixel_y, 0);

        // Reset during CAPTURE of row 2.
        glyph = 7'h12; start = 1'b1; pixel_ready = 1'b1; fetches = 0;
        for (int i = 0; i < 100 && fetches < 3; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (rom_enable) fetches++;
        end
        check("row2_fetch_address", rom_address, {7'h12, 3'd2});
        @(negedge clock);
        check("in_capture", {rom_enable, pixel_valid, busy}, 3'b001);
        reset = 1'b1;
        @(negedge clock);
        check("reset_from_capture", all_outs, 0);
        reset = 1'b0;
        any_done = 0;
        repeat (4) begin
            @(negedge clock);
            any_done |= done;
        end
        check("no_done_after_reset", any_done, 0);
        run_glyph(7'h12, 0, 0, 0);

        // Reset during a stalled SHIFT.
        glyph = 7'h33; start = 1'b1; pixel_ready = 1'b0;
        for (int i = 0; i < 20 && !pixel_valid; i++) begin
            @(negedge clock);
            start = 1'b0;
        end
        check("stalled_shift_reached", pixel_valid, 1);
        repeat (2) @(negedge clock);
        check("still_stalled", {pixel_valid, pixel_x, pixel_y}, 7'b1_000_000);
        reset = 1'b1;
        @(negedge clock);
        check("reset_from_stall", all_outs, 0);
        reset = 1'b0;
        any_done = 0;
        repeat (4) begin
            @(negedge clock);
            any_done |= done;
        end
        check("no_done_after_stall_reset", any_done, 0);
        run_glyph(7'h33, 2, 0, 0);

        // Back-to-back with start held high: second FETCH lands at cycle 83.
        run_glyph(7'h05, 0, 0, 1);
        run_glyph(7'h2A, 0, 0, 0);

        // Random glyphs with random backpressure.
        for (int k = 0; k < 4; k++) run_glyph(7'($urandom), 2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
